// File: rtl/router_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_rx
// Purpose  : Receives one packet at a time from a router output FIFO.
//            Issues registered FIFO reads, captures the header, payload and
//            parity bytes, checks header address and packet parity, and
//            keeps saturating packet / error counters.
// Ports    : clock, resetn        - clock, async active-low reset
//            vld_out, data_out    - FIFO non-empty flag and read data
//                                   (data valid the cycle after a read)
//            stall                - downstream back-pressure, blocks reads
//            read_enb             - registered FIFO read request
//            byte_out, byte_vld   - captured byte and its qualifier
//            sop, eop             - header / parity byte markers
//            pkt_done             - pulse the cycle after the parity byte
//            pkt_len              - payload length from the last header
//            parity_err, addr_err - per-packet error flags
//            pkt_cnt, err_cnt     - saturating packet / error counters
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_rx #(
    parameter logic [1:0] PORT_ID = 2'b00
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    input  logic       stall,
    output logic       read_enb,
    output logic [7:0] byte_out,
    output logic       byte_vld,
    output logic       sop,
    output logic       eop,
    output logic       pkt_done,
    output logic [5:0] pkt_len,
    output logic       parity_err,
    output logic       addr_err,
    output logic [7:0] pkt_cnt,
    output logic [7:0] err_cnt
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_HDR_WAIT = 2'd1;
    localparam logic [1:0] c_PAYLOAD  = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    logic [1:0] r_state;
    logic       r_read_enb;
    logic       r_rd_pend;      // a read was sampled by the FIFO last edge
    logic [7:0] r_byte_out;
    logic       r_byte_vld;
    logic       r_sop;
    logic       r_eop;
    logic       r_pkt_done;
    logic [5:0] r_pkt_len;
    logic       r_parity_err;
    logic       r_addr_err;
    logic [7:0] r_pkt_cnt;
    logic [7:0] r_err_cnt;
    logic [7:0] r_parity;
    logic [6:0] r_reads_left;   // reads still to be issued after the header
    logic [6:0] r_caps_left;    // bytes still to be captured after the header

    logic       w_issue;

    // Payload read request; reads_left guards against running past the packet.
    assign w_issue = vld_out && !stall && (r_reads_left != 7'd0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_read_enb   <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_byte_out   <= 8'd0;
            r_byte_vld   <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_pkt_len    <= 6'd0;
            r_parity_err <= 1'b0;
            r_addr_err   <= 1'b0;
            r_pkt_cnt    <= 8'd0;
            r_err_cnt    <= 8'd0;
            r_parity     <= 8'd0;
            r_reads_left <= 7'd0;
            r_caps_left  <= 7'd0;
        end else begin
            // Fixed one-cycle read latency: whatever read the FIFO sampled
            // last edge is captured now, regardless of the current request.
            r_rd_pend  <= r_read_enb;
            r_byte_vld <= r_rd_pend;
            if (r_rd_pend) begin
                r_byte_out <= data_out;
            end
            r_read_enb <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_pkt_done <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (vld_out && !stall) begin
                        r_read_enb <= 1'b1;
                        r_state    <= c_HDR_WAIT;
                    end
                end

                c_HDR_WAIT: begin
                    if (r_rd_pend) begin
                        r_sop        <= 1'b1;
                        r_pkt_len    <= data_out[7:2];
                        r_addr_err   <= (data_out[1:0] != PORT_ID);
                        r_parity_err <= 1'b0;
                        r_parity     <= data_out;
                        // payload bytes plus the trailing parity byte
                        r_reads_left <= {1'b0, data_out[7:2]} + 7'd1;
                        r_caps_left  <= {1'b0, data_out[7:2]} + 7'd1;
                        r_state      <= c_PAYLOAD;
                    end
                end

                c_PAYLOAD: begin
                    if (w_issue) begin
                        r_read_enb   <= 1'b1;
                        r_reads_left <= r_reads_left - 7'd1;
                    end
                    if (r_rd_pend) begin
                        if (r_caps_left == 7'd1) begin
                            // last byte of the packet is the parity byte
                            r_eop        <= 1'b1;
                            r_parity_err <= (data_out != r_parity);
                            r_caps_left  <= 7'd0;
                            r_state      <= c_DONE;
                        end else begin
                            r_parity    <= r_parity ^ data_out;
                            r_caps_left <= r_caps_left - 7'd1;
                        end
                    end
                end

                c_DONE: begin
                    // no read is issued here, guaranteeing an idle cycle
                    r_pkt_done <= 1'b1;
                    if (r_pkt_cnt != 8'hFF) begin
                        r_pkt_cnt <= r_pkt_cnt + 8'd1;
                    end
                    if ((r_parity_err || r_addr_err) && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign read_enb   = r_read_enb;
    assign byte_out   = r_byte_out;
    assign byte_vld   = r_byte_vld;
    assign sop        = r_sop;
    assign eop        = r_eop;
    assign pkt_done   = r_pkt_done;
    assign pkt_len    = r_pkt_len;
    assign parity_err = r_parity_err;
    assign addr_err   = r_addr_err;
    assign pkt_cnt    = r_pkt_cnt;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_rx
// Purpose  : Directed self-checking bench for router_pkt_rx. Three receivers
//            with PORT_ID 2, 1 and 0 share one FIFO model (read by the
//            PORT_ID=2 instance; all three issue identical reads), so each
//            scenario can observe the instance whose address it targets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_rx;

    logic       clock      = 1'b0;
    logic       resetn     = 1'b1;
    logic       stall      = 1'b0;
    logic       fifo_hold  = 1'b0;
    logic       fifo_flush = 1'b0;
    logic [7:0] data_out   = 8'd0;
    logic       vld_out;

    logic [7:0] mem [0:1023];
    int         wp = 0;
    int         rp = 0;

    logic       read_enb_p2, byte_vld_p2, sop_p2, eop_p2, pkt_done_p2, parity_err_p2, addr_err_p2;
    logic [7:0] byte_out_p2, pkt_cnt_p2, err_cnt_p2;
    logic [5:0] pkt_len_p2;
    logic       read_enb_p1, byte_vld_p1, sop_p1, eop_p1, pkt_done_p1, parity_err_p1, addr_err_p1;
    logic [7:0] byte_out_p1, pkt_cnt_p1, err_cnt_p1;
    logic [5:0] pkt_len_p1;
    logic       read_enb_p0, byte_vld_p0, sop_p0, eop_p0, pkt_done_p0, parity_err_p0, addr_err_p0;
    logic [7:0] byte_out_p0, pkt_cnt_p0, err_cnt_p0;
    logic [5:0] pkt_len_p0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_vld_cyc = 0;
    int done_cyc     = 0;

    logic [7:0] cap_q [$];
    bit         sop_q [$];
    bit         eop_q [$];
    logic [7:0] exp_q [$];

    router_pkt_rx #(.PORT_ID(2'd2)) u_dut_p2 (
        .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out), .stall(stall),
        .read_enb(read_enb_p2), .byte_out(byte_out_p2), .byte_vld(byte_vld_p2), .sop(sop_p2),
        .eop(eop_p2), .pkt_done(pkt_done_p2), .pkt_len(pkt_len_p2), .parity_err(parity_err_p2),
        .addr_err(addr_err_p2), .pkt_cnt(pkt_cnt_p2), .err_cnt(err_cnt_p2));

    router_pkt_rx #(.PORT_ID(2'd1)) u_dut_p1 (
        .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out), .stall(stall),
        .read_enb(read_enb_p1), .byte_out(byte_out_p1), .byte_vld(byte_vld_p1), .sop(sop_p1),
        .eop(eop_p1), .pkt_done(pkt_done_p1), .pkt_len(pkt_len_p1), .parity_err(parity_err_p1),
        .addr_err(addr_err_p1), .pkt_cnt(pkt_cnt_p1), .err_cnt(err_cnt_p1));

    router_pkt_rx #(.PORT_ID(2'd0)) u_dut_p0 (
        .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out), .stall(stall),
        .read_enb(read_enb_p0), .byte_out(byte_out_p0), .byte_vld(byte_vld_p0), .sop(sop_p0),
        .eop(eop_p0), .pkt_done(pkt_done_p0), .pkt_len(pkt_len_p0), .parity_err(parity_err_p0),
        .addr_err(addr_err_p0), .pkt_cnt(pkt_cnt_p0), .err_cnt(err_cnt_p0));

    always #5 clock = ~clock;

    // FIFO model: registered read data, reads of an empty FIFO are ignored.
    assign vld_out = (wp != rp) && !fifo_hold;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (fifo_flush) begin
            rp <= wp;
        end else if (read_enb_p2 && (rp != wp)) begin
            data_out <= mem[rp[9:0]];
            rp       <= rp + 1;
        end
    end

    // Capture monitor on the falling edge.
    always @(negedge clock) begin
        if (byte_vld_p2) begin
            cap_q.push_back(byte_out_p2);
            sop_q.push_back(sop_p2);
            eop_q.push_back(eop_p2);
            last_vld_cyc = cyc;
        end
        if (pkt_done_p2) begin
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wp[9:0]] = b;
        exp_q.push_back(b);
        wp = wp + 1;
    endtask

    task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] seed, input bit corrupt);
        logic [7:0] p;
        logic [7:0] b;
        p = hdr;
        push_byte(hdr);
        for (int i = 0; i < int'(hdr[7:2]); i++) begin
            b = seed + 8'(i);
            p = p ^ b;
            push_byte(b);
        end
        push_byte(corrupt ? ~p : p);
    endtask

    task automatic clear_caps();
        cap_q.delete();
        sop_q.delete();
        eop_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        tick();
        resetn     = 1'b0;
        fifo_flush = 1'b1;
        tick();
        tick();
        resetn     = 1'b1;
        fifo_flush = 1'b0;
        clear_caps();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (pkt_done_p2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_caps(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (cap_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // index of the first captured byte differing from the expected stream,
    // -2 on a length difference, -1 when identical
    function automatic int first_bad();
        if (cap_q.size() != exp_q.size()) return -2;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (cap_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        logic [36:0] outs;
        resetn = 1'b0;
        fifo_flush = 1'b1;
        #1;
        outs = {read_enb_p2, byte_out_p2, byte_vld_p2, sop_p2, eop_p2, pkt_done_p2,
                pkt_len_p2, parity_err_p2, addr_err_p2, pkt_cnt_p2, err_cnt_p2};
        vectors++;
        if (outs !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %0h expected 0", outs);
        end
        tick();
        tick();
        resetn = 1'b1;
        fifo_flush = 1'b0;
        clear_caps();
    endtask

    task automatic test_basic();
        bit ok;
        logic [6:0] sop_v, eop_v;
        int fb;
        do_reset();
        push_pkt(8'h16, 8'h10, 1'b0);
        wait_done(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_done: got no pkt_done expected pulse within 200 cycles");
        end
        sop_v = '0;
        eop_v = '0;
        for (int i = 0; i < 7 && i < sop_q.size(); i++) begin
            sop_v[i] = sop_q[i];
            eop_v[i] = eop_q[i];
        end
        vectors++;
        if (cap_q.size() !== 7) begin
            miscompares++;
            $display("FAIL basic_count: got %0d bytes expected 7", cap_q.size());
        end
        vectors++;
        if (sop_v !== 7'b0000001 || eop_v !== 7'b1000000) begin
            miscompares++;
            $display("FAIL basic_sop_eop: got sop=%b eop=%b expected sop=0000001 eop=1000000", sop_v, eop_v);
        end
        fb = first_bad();
        vectors++;
        if (fb !== -1) begin
            miscompares++;
            $display("FAIL basic_stream: got first bad index %0d expected -1", fb);
        end
        vectors++;
        if ({pkt_len_p2, parity_err_p2, addr_err_p2, pkt_cnt_p2, err_cnt_p2} !== {6'd5, 1'b0, 1'b0, 8'd1, 8'd0}) begin
            miscompares++;
            $display("FAIL basic_status: got len=%0d perr=%b aerr=%b pcnt=%0d ecnt=%0d expected 5 0 0 1 0",
                     pkt_len_p2, parity_err_p2, addr_err_p2, pkt_cnt_p2, err_cnt_p2);
        end
        vectors++;
        if (done_cyc - last_vld_cyc !== 1) begin
            miscompares++;
            $display("FAIL basic_done_latency: got %0d expected 1", done_cyc - last_vld_cyc);
        end
        tick();
        vectors++;
        if (pkt_done_p2 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_width: got %b expected 0", pkt_done_p2);
        end
    endtask

    task automatic test_parity_err();
        bit ok;
        int fb;
        do_reset();
        push_pkt(8'h39, 8'hA0, 1'b1);
        wait_done(300, ok);
        fb = first_bad();
        vectors++;
        if (!ok || fb !== -1) begin
            miscompares++;
            $display("FAIL perr_stream: got done=%b first_bad=%0d expected 1 -1", ok, fb);
        end
        vectors++;
        if ({pkt_len_p1, parity_err_p1, addr_err_p1, pkt_cnt_p1, err_cnt_p1} !== {6'd14, 1'b1, 1'b0, 8'd1, 8'd1}) begin
            miscompares++;
            $display("FAIL perr_status: got len=%0d perr=%b aerr=%b pcnt=%0d ecnt=%0d expected 14 1 0 1 1",
                     pkt_len_p1, parity_err_p1, addr_err_p1, pkt_cnt_p1, err_cnt_p1);
        end
        // a following good packet clears the sticky flag at its header
        tick();
        push_pkt(8'h05, 8'h33, 1'b0);
        wait_done(200, ok);
        vectors++;
        if (!ok || {parity_err_p1, pkt_cnt_p1, err_cnt_p1} !== {1'b0, 8'd2, 8'd1}) begin
            miscompares++;
            $display("FAIL perr_clear: got done=%b perr=%b pcnt=%0d ecnt=%0d expected 1 0 2 1",
                     ok, parity_err_p1, pkt_cnt_p1, err_cnt_p1);
        end
    endtask

    task automatic test_len0();
        bit ok;
        do_reset();
        push_pkt(8'h02, 8'h00, 1'b0);
        wait_done(100, ok);
        vectors++;
        if (!ok || cap_q.size() !== 2) begin
            miscompares++;
            $display("FAIL len0_count: got done=%b bytes=%0d expected 1 2", ok, cap_q.size());
        end
        vectors++;
        if ({addr_err_p0, parity_err_p0, err_cnt_p0, addr_err_p2} !== {1'b1, 1'b0, 8'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL len0_addr: got aerr0=%b perr0=%b ecnt0=%0d aerr2=%b expected 1 0 1 0",
                     addr_err_p0, parity_err_p0, err_cnt_p0, addr_err_p2);
        end
        vectors++;
        if (done_cyc - last_vld_cyc !== 1) begin
            miscompares++;
            $display("FAIL len0_latency: got %0d expected 1", done_cyc - last_vld_cyc);
        end
    endtask

    task automatic test_stall_vld();
        bit ok;
        bit bad;
        int fb;
        do_reset();
        push_pkt(8'h42, 8'h50, 1'b0);
        wait_caps(5, 100, ok);
        stall = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (read_enb_p2 !== 1'b0) bad = 1'b1;
        end
        stall = 1'b0;
        vectors++;
        if (!ok || bad) begin
            miscompares++;
            $display("FAIL stall_read_enb: got reached=%b read_during_stall=%b expected 1 0", ok, bad);
        end
        wait_caps(10, 100, ok);
        fifo_hold = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (read_enb_p2 !== 1'b0) bad = 1'b1;
        end
        fifo_hold = 1'b0;
        vectors++;
        if (!ok || bad) begin
            miscompares++;
            $display("FAIL vld_low_read_enb: got reached=%b read_while_empty=%b expected 1 0", ok, bad);
        end
        wait_done(300, ok);
        fb = first_bad();
        vectors++;
        if (!ok || fb !== -1 || cap_q.size() !== 18) begin
            miscompares++;
            $display("FAIL stall_stream: got done=%b first_bad=%0d bytes=%0d expected 1 -1 18", ok, fb, cap_q.size());
        end
        vectors++;
        if ({pkt_len_p2, parity_err_p2, pkt_cnt_p2} !== {6'd16, 1'b0, 8'd1}) begin
            miscompares++;
            $display("FAIL stall_status: got len=%0d perr=%b pcnt=%0d expected 16 0 1", pkt_len_p2, parity_err_p2, pkt_cnt_p2);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit bad;
        int fb;
        logic [36:0] outs;
        do_reset();
        push_pkt(8'h16, 8'h77, 1'b0);
        wait_caps(4, 100, ok);
        resetn = 1'b0;
        fifo_flush = 1'b1;
        #1;
        outs = {read_enb_p2, byte_out_p2, byte_vld_p2, sop_p2, eop_p2, pkt_done_p2,
                pkt_len_p2, parity_err_p2, addr_err_p2, pkt_cnt_p2, err_cnt_p2};
        vectors++;
        if (!ok || outs !== 37'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got reached=%b outs=%0h expected 1 0", ok, outs);
        end
        tick();
        tick();
        resetn = 1'b1;
        fifo_flush = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (read_enb_p2 !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL post_reset_idle: got read_enb=1 with empty FIFO expected 0");
        end
        clear_caps();
        push_pkt(8'h16, 8'h88, 1'b0);
        wait_done(200, ok);
        fb = first_bad();
        vectors++;
        if (!ok || fb !== -1 || {pkt_cnt_p2, err_cnt_p2, parity_err_p2, addr_err_p2} !== {8'd1, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset_recover: got done=%b first_bad=%0d pcnt=%0d ecnt=%0d expected 1 -1 1 0",
                     ok, fb, pkt_cnt_p2, err_cnt_p2);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int fb;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            push_pkt(8'h02, 8'h00, 1'b0);
        end
        n = 0;
        for (int i = 0; i < 5000 && n < 256; i++) begin
            tick();
            if (pkt_done_p2) n++;
        end
        tick();
        fb = first_bad();
        vectors++;
        if (n !== 256 || fb !== -1) begin
            miscompares++;
            $display("FAIL b2b_packets: got done=%0d first_bad=%0d expected 256 -1", n, fb);
        end
        vectors++;
        if ({pkt_cnt_p2, err_cnt_p2, err_cnt_p0} !== {8'd255, 8'd0, 8'd255}) begin
            miscompares++;
            $display("FAIL b2b_saturate: got pcnt=%0d ecnt2=%0d ecnt0=%0d expected 255 0 255",
                     pkt_cnt_p2, err_cnt_p2, err_cnt_p0);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_parity_err();
        test_len0();
        test_stall_vld();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
